regfile_read_port: RTL and testbench

- Handshaked read-side front end for the 32x32 processor register array built from enable/clear registers.
- Accepts read requests, samples the selected register with same-cycle write forwarding, and returns data through a 2-entry response buffer.
- Lets a requester such as decode or a debug/readback unit read registers without timing coupling to the write side.

---
 rtl/regfile_read_port.sv | 133 +++++++++++++
 tb/tb_regfile_read_port.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_port.sv
// Read-side front end for the register array. Requests are handshaked in,
// the selected register is sampled with same-cycle write forwarding, and the
// result is returned through a 2-entry response FIFO.
// Ports:
//   clk, clr                   clock, synchronous active-high reset
//   req_valid/req_ready        request handshake, req_addr selects register
//   wr_en/wr_addr/wr_data      array write happening this cycle (forwarding)
//   reg_q                      flattened array outputs, reg i at [i*WIDTH +: WIDTH]
//   resp_valid/resp_ready      response handshake
//   resp_data/resp_addr        head entry of the response FIFO
//   count                      occupied FIFO entries (0..2)
module regfile_read_port #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [NREG*WIDTH-1:0]  reg_q,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WIDTH-1:0]       resp_data,
    output logic [ADDR_W-1:0]      resp_addr,
    output logic [1:0]             count
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } entry_t;

    entry_t            buf_q [2];
    entry_t            buf_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              resp_valid_q, resp_valid_d;
    logic              req_ready_q, req_ready_d;
    logic [WIDTH-1:0]  resp_data_q, resp_data_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;

    logic              accept;
    logic              pop;
    logic [WIDTH-1:0]  sample_data;

    // Value captured on accept: zero for r0/out-of-range, else forwarded write or array
    always_comb begin
        sample_data = '0;
        if (req_addr != '0 && 32'(req_addr) < NREG) begin
            if (wr_en && wr_addr == req_addr) begin
                sample_data = wr_data;
            end else begin
                sample_data = reg_q[32'(req_addr) * WIDTH +: WIDTH];
            end
        end
    end

    // FIFO next state; head outputs and ready are precomputed so they come from flops
    always_comb begin
        buf_d        = buf_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        resp_data_d  = resp_data_q;
        resp_addr_d  = resp_addr_q;

        accept = req_valid && req_ready_q;
        pop    = resp_valid_q && resp_ready;

        if (accept) begin
            buf_d[wr_ptr_q].addr = req_addr;
            buf_d[wr_ptr_q].data = sample_data;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        resp_valid_d = (count_d != 2'd0);
        req_ready_d  = (count_d < FULL);
        // Head data holds its last value once the FIFO drains
        if (count_d != 2'd0) begin
            resp_data_d = buf_d[rd_ptr_d].data;
            resp_addr_d = buf_d[rd_ptr_d].addr;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (clr) begin
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_data_q  <= '0;
            resp_addr_q  <= '0;
        end else begin
            buf_q        <= buf_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
            resp_data_q  <= resp_data_d;
            resp_addr_q  <= resp_addr_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_addr  = resp_addr_q;
    assign count      = count_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// Testbench for regfile_read_port: directed scenarios plus a randomized run
// against a queue-based reference model of the response FIFO.
module tb_regfile_read_port;

    localparam int unsigned W    = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } ent_t;

    logic              clk = 1'b0;
    logic              clr;
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_addr;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [W-1:0]      wr_data;
    logic [NREG*W-1:0] reg_q;
    logic              resp_valid;
    logic              resp_ready;
    logic [W-1:0]      resp_data;
    logic [AW-1:0]     resp_addr;
    logic [1:0]        count;

    logic [W-1:0]      regs [NREG];
    ent_t              mq [$];
    logic [W-1:0]      m_data;
    logic [AW-1:0]     m_addr;
    int                checks = 0;
    int                passed = 0;

    regfile_read_port dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .reg_q(reg_q),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_addr(resp_addr), .count(count)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < int'(NREG); i++) reg_q[i*W +: W] = regs[i];
    end

    function automatic logic [W-1:0] ref_sample(input logic [AW-1:0] a);
        if (a == 0 || int'(a) >= int'(NREG)) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return regs[a];
    endfunction

    // Advance one clock edge and update the reference model and the array
    task automatic tick();
        logic do_pop, do_acc;
        ent_t e;
        do_pop = (mq.size() > 0) && resp_ready;
        do_acc = req_valid && (mq.size() < 2);
        e.addr = req_addr;
        e.data = ref_sample(req_addr);
        @(posedge clk);
        #1;
        if (clr) begin
            mq.delete();
            m_data = '0;
            m_addr = '0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_acc) mq.push_back(e);
            if (mq.size() > 0) begin
                m_data = mq[0].data;
                m_addr = mq[0].addr;
            end
        end
        if (wr_en && wr_addr != 0) regs[wr_addr] = wr_data;
    endtask

    task automatic idle_inputs();
        clr = 0; req_valid = 0; req_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
        resp_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        clr = 1; req_valid = 1; req_addr = 5'd3;
        tick();
        tick();
        clr = 0; req_valid = 0;
        checks++; if (count !== 2'd0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
        checks++; if (resp_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", resp_valid); else passed++;
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_ready); else passed++;
        checks++; if (resp_data !== 32'h0 || resp_addr !== 5'd0)
            $display("FAIL reset_head got=%h/%0d exp=0/0", resp_data, resp_addr); else passed++;
    endtask

    task automatic test_basic();
        regs[5] = 32'h0000_00A5;
        req_valid = 1; req_addr = 5'd5; resp_ready = 1;
        tick();
        req_valid = 0;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h0000_00A5 || resp_addr !== 5'd5)
            $display("FAIL basic_resp got=%b/%h/%0d exp=1/000000a5/5", resp_valid, resp_data, resp_addr); else passed++;
        checks++; if (count !== 2'd1) $display("FAIL basic_count1 got=%0d exp=1", count); else passed++;
        tick();
        checks++; if (count !== 2'd0 || resp_valid !== 1'b0 || resp_data !== 32'h0000_00A5)
            $display("FAIL basic_drain got=%0d/%b/%h exp=0/0/000000a5", count, resp_valid, resp_data); else passed++;
    endtask

    task automatic test_forward();
        regs[7] = 32'h1;
        req_valid = 1; req_addr = 5'd7; wr_en = 1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF; resp_ready = 1;
        tick();
        checks++; if (resp_data !== 32'hDEAD_BEEF) $display("FAIL fwd_data got=%h exp=deadbeef", resp_data); else passed++;
        regs[0] = 32'h5555_5555;
        req_addr = 5'd0; wr_addr = 5'd0; wr_data = 32'h1234_5678;
        tick();
        req_valid = 0; wr_en = 0;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h0 || resp_addr !== 5'd0)
            $display("FAIL fwd_r0 got=%b/%h/%0d exp=1/00000000/0", resp_valid, resp_data, resp_addr); else passed++;
        tick();
        regs[0] = '0;
    endtask

    task automatic test_full_stall();
        logic [W-1:0] exp_seq [3];
        regs[1] = 32'hA1; regs[2] = 32'hB2; regs[3] = 32'hC3;
        exp_seq[0] = 32'hA1; exp_seq[1] = 32'hB2; exp_seq[2] = 32'hC3;
        resp_ready = 0; req_valid = 1;
        req_addr = 5'd1; tick();
        req_addr = 5'd2; tick();
        req_addr = 5'd3; tick();
        checks++; if (count !== 2'd2 || req_ready !== 1'b0)
            $display("FAIL full_state got=%0d/%b exp=2/0", count, req_ready); else passed++;
        checks++; if (resp_data !== 32'hA1 || resp_addr !== 5'd1)
            $display("FAIL full_head got=%h/%0d exp=000000a1/1", resp_data, resp_addr); else passed++;
        // Pop frees a slot only for the following cycle
        resp_ready = 1;
        for (int k = 1; k < 3; k++) begin
            tick();
            if (k == 2) req_valid = 0;
            checks++; if (resp_valid !== 1'b1 || resp_data !== exp_seq[k] || resp_addr !== 5'(k + 1))
                $display("FAIL drain_%0d got=%b/%h/%0d exp=1/%h/%0d", k, resp_valid, resp_data, resp_addr, exp_seq[k], k + 1);
            else passed++;
        end
        checks++; if (count !== 2'd1) $display("FAIL drain_count got=%0d exp=1", count); else passed++;
        tick();
        checks++; if (count !== 2'd0 || resp_valid !== 1'b0)
            $display("FAIL drain_empty got=%0d/%b exp=0/0", count, resp_valid); else passed++;
    endtask

    task automatic test_simul();
        regs[10] = 32'h1010; regs[11] = 32'h1111;
        resp_ready = 0; req_valid = 1; req_addr = 5'd10;
        tick();
        resp_ready = 1; req_addr = 5'd11;
        tick();
        req_valid = 0;
        checks++; if (count !== 2'd1 || resp_data !== 32'h1111 || resp_addr !== 5'd11)
            $display("FAIL simul got=%0d/%h/%0d exp=1/00001111/11", count, resp_data, resp_addr); else passed++;
        tick();
    endtask

    task automatic test_snapshot();
        regs[4] = 32'h11;
        resp_ready = 0; req_valid = 1; req_addr = 5'd4;
        tick();
        req_valid = 0; wr_en = 1; wr_addr = 5'd4; wr_data = 32'h22;
        tick();
        wr_en = 0;
        tick();
        checks++; if (resp_data !== 32'h11 || regs[4] !== 32'h22)
            $display("FAIL snapshot got=%h exp=00000011", resp_data); else passed++;
        resp_ready = 1;
        tick();
    endtask

    task automatic test_clr_full();
        resp_ready = 0; req_valid = 1; req_addr = 5'd9;
        tick(); tick();
        checks++; if (count !== 2'd2) $display("FAIL clr_fill got=%0d exp=2", count); else passed++;
        clr = 1;
        tick();
        clr = 0; req_valid = 0;
        checks++; if (count !== 2'd0 || resp_valid !== 1'b0 || resp_data !== 32'h0 || req_ready !== 1'b1)
            $display("FAIL clr_full got=%0d/%b/%h/%b exp=0/0/0/1", count, resp_valid, resp_data, req_ready); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            clr        = ($urandom_range(0, 49) == 0);
            req_valid  = $urandom_range(0, 3) != 0;
            req_addr   = 5'($urandom_range(0, 31));
            resp_ready = $urandom_range(0, 2) != 0;
            wr_en      = $urandom_range(0, 1) == 1;
            wr_addr    = ($urandom_range(0, 2) == 0) ? req_addr : 5'($urandom_range(0, 31));
            wr_data    = $urandom();
            if ($urandom_range(0, 9) == 0) regs[$urandom_range(0, 31)] = $urandom();
            tick();
            checks++;
            if (resp_valid !== (mq.size() > 0) || count !== 2'(mq.size()) || req_ready !== (mq.size() < 2)
                || resp_data !== m_data || resp_addr !== m_addr)
                $display("FAIL rand_%0d got=%b/%0d/%b/%h/%0d exp=%b/%0d/%b/%h/%0d", n,
                         resp_valid, count, req_ready, resp_data, resp_addr,
                         mq.size() > 0, mq.size(), mq.size() < 2, m_data, m_addr);
            else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < int'(NREG); i++) regs[i] = 32'(i) * 32'h0101_0101;
        m_data = '0;
        m_addr = '0;
        test_reset();
        test_basic();
        test_forward();
        test_full_stall();
        test_simul();
        test_snapshot();
        test_clr_full();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
